instr_fetch_seq: RTL

- Self-sequencing instruction fetch unit for the multicycle datapath.
- Replaces the hand-driven per-byte irwrite strobes and pcen/pcsrc fetch sequencing with an internal FSM.
- Assembles an INSTR_W-bit instruction from BEATS consecutive WIDTH-bit memory words.
- Handshakes with a variable-latency memory (memrd/memready) and with the decode/control stage (instr_valid/instr_ack).
- Sits between the memory port and the instruction register feeding the register file and ALU.

---
 rtl/instr_fetch_seq_if.sv | 32 +++
 rtl/instr_fetch_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/instr_fetch_seq_if.sv
// Fetch-unit bundle: memory read port, redirect inputs and the decode-side instruction handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_seq_if #(
    parameter int WIDTH   = 8,
    parameter int INSTR_W = 32
);
    localparam int BEATS = INSTR_W / WIDTH;

    logic               start;
    logic               pcload;
    logic [WIDTH-1:0]   pcnext;
    logic               memrd;
    logic [WIDTH-1:0]   adr;
    logic               memready;
    logic [WIDTH-1:0]   memdata;
    logic [BEATS-1:0]   irwrite;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ack;
    logic [WIDTH-1:0]   pcvalue;
    logic               busy;

    modport master (
        input  start, pcload, pcnext, memready, memdata, instr_ack,
        output memrd, adr, irwrite, instr, instr_valid, pcvalue, busy
    );

    modport slave (
        output start, pcload, pcnext, memready, memdata, instr_ack,
        input  memrd, adr, irwrite, instr, instr_valid, pcvalue, busy
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Self-sequencing fetch: assembles INSTR_W bits from BEATS memory words starting at pc.
// Latency: BEATS+1 cycles from start to instr_valid with memready high; each wait cycle adds one.
// Backpressure: memready stalls the current beat indefinitely; HOLD keeps instr until instr_ack.
module instr_fetch_seq #(
    parameter int               WIDTH    = 8,
    parameter int               INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_seq_if.master   bus
);
    localparam int BEATS = INSTR_W / WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BW-1:0]      beat;
    logic [WIDTH-1:0]   pc;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_vld_q;
    logic               capture;
    logic               last_beat;
    logic [BEATS-1:0]   irwrite_d;

    // A redirect in REQ wins over the beat, so nothing is captured that cycle.
    assign capture   = (state == REQ) && bus.memready && !bus.pcload;
    assign last_beat = (beat == BW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (capture && last_beat) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ack) begin
                    state_nxt = bus.start ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irwrite_d = '0;
        for (int b = 0; b < BEATS; b++) begin
            irwrite_d[b] = capture && (beat == BW'(b));
        end
        bus.memrd       = (state == REQ);
        bus.busy        = (state == REQ);
        bus.irwrite     = irwrite_d;
        bus.adr         = pc + WIDTH'(beat);
        bus.instr       = instr_q;
        bus.instr_valid = instr_vld_q;
        bus.pcvalue     = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            beat        <= '0;
            instr_q     <= '0;
            instr_vld_q <= 1'b0;
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (irwrite_d[b]) begin
                    instr_q[b*WIDTH +: WIDTH] <= bus.memdata;
                end
            end

            if (bus.pcload) begin
                pc <= bus.pcnext;
                if (state == REQ) begin
                    beat <= '0;
                end
            end else if (capture) begin
                if (last_beat) begin
                    pc   <= pc + WIDTH'(BEATS);
                    beat <= '0;
                end else begin
                    beat <= beat + BW'(1);
                end
            end

            if (capture && last_beat) begin
                instr_vld_q <= 1'b1;
            end else if (state == HOLD && bus.instr_ack) begin
                instr_vld_q <= 1'b0;
            end
        end
    end
endmodule
